// File: rtl/mem_pkg.sv
// Shared types and helpers for the CPU-side load/store path.
package mem_pkg;

    localparam int MEM_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2
    } mem_size_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR      = 3'd3,
        RESP    = 3'd4
    } lsu_state_t;

    // A request is rejected when its size code is unknown or when the
    // address does not sit on a natural boundary for that size.
    function automatic logic req_is_bad(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            MEM_BYTE: bad = 1'b0;
            MEM_HALF: bad = addr_lo[0];
            MEM_WORD: bad = (addr_lo != 2'b00);
            default:  bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane handling: extracts and extends load data, and merges
// sub-word store data into a word read back from memory.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]                size,
    input  logic                      is_unsigned,
    input  logic [1:0]                addr_lo,
    input  logic [MEM_DATA_WIDTH-1:0] mem_word,
    input  logic [MEM_DATA_WIDTH-1:0] store_data,
    output logic [MEM_DATA_WIDTH-1:0] load_data,
    output logic [MEM_DATA_WIDTH-1:0] merged_word
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic        byte_fill;
    logic        half_fill;

    // Pick the addressed lane and widen it to 32 bits, sign or zero filled.
    always_comb begin
        byte_lane = mem_word[{addr_lo, 3'b000} +: 8];
        half_lane = mem_word[{addr_lo[1], 4'b0000} +: 16];
        byte_fill = byte_lane[7] & ~is_unsigned;
        half_fill = half_lane[15] & ~is_unsigned;
        case (size)
            MEM_BYTE: load_data = {{24{byte_fill}}, byte_lane};
            MEM_HALF: load_data = {{16{half_fill}}, half_lane};
            default:  load_data = mem_word;
        endcase
    end

    // Overwrite only the addressed lane; all other bits come from memory.
    always_comb begin
        merged_word = mem_word;
        case (size)
            MEM_BYTE: merged_word[{addr_lo, 3'b000} +: 8]    = store_data[7:0];
            MEM_HALF: merged_word[{addr_lo[1], 4'b0000} +: 16] = store_data[15:0];
            default:  merged_word = store_data;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Load/store initiator for a word-addressed ready/valid data memory.
// Sub-word stores are done as read-modify-write since the memory has
// no byte enables.
module mem_lsu
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
)
(
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_req_valid,
    output logic                      o_req_ready,
    input  logic                      i_req_write,
    input  logic [1:0]                i_req_size,
    input  logic                      i_req_unsigned,
    input  logic [31:0]               i_req_addr,
    input  logic [31:0]               i_req_wdata,
    output logic                      o_resp_valid,
    output logic [31:0]               o_resp_rdata,
    output logic                      o_resp_err,
    output logic [ADDR_WIDTH-1:0]     o_mem_addr,
    output logic [31:0]               o_mem_data,
    output logic                      o_mem_wr_valid,
    input  logic                      i_mem_wr_ready,
    output logic                      o_mem_rd_ready,
    input  logic [31:0]               i_mem_data,
    input  logic                      i_mem_rd_valid
);

    lsu_state_t state;
    lsu_state_t state_next;

    logic                  req_write;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [ADDR_WIDTH+1:0] req_addr;
    logic [15:0]           req_wdata;
    logic                  req_err;
    logic [31:0]           data_q;

    logic [31:0]           load_data;
    logic [31:0]           merged_word;
    logic                  unused_addr_hi;

    // Address bits above the attached memory are deliberately dropped.
    assign unused_addr_hi = ^i_req_addr[31:ADDR_WIDTH+2];

    mem_lane_align u_align (
        .size        (req_size),
        .is_unsigned (req_unsigned),
        .addr_lo     (req_addr[1:0]),
        .mem_word    (i_mem_data),
        .store_data  ({16'h0000, req_wdata}),
        .load_data   (load_data),
        .merged_word (merged_word)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and output decode; every output is forced low during reset.
    always_comb begin
        state_next     = state;
        o_req_ready    = 1'b0;
        o_mem_rd_ready = 1'b0;
        o_mem_wr_valid = 1'b0;
        o_mem_data     = '0;
        o_mem_addr     = '0;
        o_resp_valid   = 1'b0;
        o_resp_rdata   = '0;
        o_resp_err     = 1'b0;
        case (state)
            IDLE: begin
                if (i_req_valid) begin
                    if (req_is_bad(i_req_size, i_req_addr[1:0])) begin
                        state_next = RESP;
                    end else if (!i_req_write || (i_req_size != MEM_WORD)) begin
                        state_next = RD_REQ;
                    end else begin
                        state_next = WR;
                    end
                end
            end
            RD_REQ: begin
                state_next = RD_WAIT;
            end
            RD_WAIT: begin
                if (i_mem_rd_valid) begin
                    state_next = req_write ? WR : RESP;
                end
            end
            WR: begin
                if (i_mem_wr_ready) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (!i_rst) begin
            o_mem_addr = req_addr[ADDR_WIDTH+1:2];
            case (state)
                IDLE:    o_req_ready = 1'b1;
                RD_REQ:  o_mem_rd_ready = 1'b1;
                WR: begin
                    o_mem_wr_valid = 1'b1;
                    o_mem_data     = data_q;
                end
                RESP: begin
                    o_resp_valid = 1'b1;
                    o_resp_err   = req_err;
                    o_resp_rdata = (req_write || req_err) ? 32'h0000_0000 : data_q;
                end
                default: ;
            endcase
        end
    end

    // Request capture on accept, then the read word (extended for loads,
    // merged for sub-word stores) once memory returns it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            req_write    <= 1'b0;
            req_size     <= 2'b00;
            req_unsigned <= 1'b0;
            req_addr     <= '0;
            req_wdata    <= '0;
            req_err      <= 1'b0;
            data_q       <= '0;
        end else if ((state == IDLE) && i_req_valid) begin
            req_write    <= i_req_write;
            req_size     <= i_req_size;
            req_unsigned <= i_req_unsigned;
            req_addr     <= i_req_addr[ADDR_WIDTH+1:0];
            req_wdata    <= i_req_wdata[15:0];
            req_err      <= req_is_bad(i_req_size, i_req_addr[1:0]);
            data_q       <= i_req_wdata;
        end else if ((state == RD_WAIT) && i_mem_rd_valid) begin
            data_q <= req_write ? merged_word : load_data;
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard testbench for mem_lsu with a byte-level reference model and a
// ready/valid memory responder.
module tb_mem_lsu;

    localparam int AW = 10;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_req_valid;
    logic          o_req_ready;
    logic          i_req_write;
    logic [1:0]    i_req_size;
    logic          i_req_unsigned;
    logic [31:0]   i_req_addr;
    logic [31:0]   i_req_wdata;
    logic          o_resp_valid;
    logic [31:0]   o_resp_rdata;
    logic          o_resp_err;
    logic [AW-1:0] o_mem_addr;
    logic [31:0]   o_mem_data;
    logic          o_mem_wr_valid;
    logic          i_mem_wr_ready;
    logic          o_mem_rd_ready;
    logic [31:0]   i_mem_data;
    logic          i_mem_rd_valid;

    mem_lsu #(.ADDR_WIDTH(AW)) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_req_valid    (i_req_valid),
        .o_req_ready    (o_req_ready),
        .i_req_write    (i_req_write),
        .i_req_size     (i_req_size),
        .i_req_unsigned (i_req_unsigned),
        .i_req_addr     (i_req_addr),
        .i_req_wdata    (i_req_wdata),
        .o_resp_valid   (o_resp_valid),
        .o_resp_rdata   (o_resp_rdata),
        .o_resp_err     (o_resp_err),
        .o_mem_addr     (o_mem_addr),
        .o_mem_data     (o_mem_data),
        .o_mem_wr_valid (o_mem_wr_valid),
        .i_mem_wr_ready (i_mem_wr_ready),
        .o_mem_rd_ready (o_mem_rd_ready),
        .i_mem_data     (i_mem_data),
        .i_mem_rd_valid (i_mem_rd_valid)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Cycle counter used to measure response latency.
    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0]   rdata;
        logic          err;
        int            reads;
        int            writes;
        int            lat;
        int            acc;
        logic          chk_lat;
        logic [AW-1:0] maddr;
        logic [31:0]   wdata;
    } exp_t;

    exp_t sb[$];

    logic [7:0] ref_mem [0:4095];

    // Memory responder: same-cycle write accept (or stalled), reads return
    // rd_lat cycles after the strobe.
    logic [31:0]   bram [0:(1<<AW)-1];
    int            rd_lat = 1;
    int            rd_count = 0;
    logic [31:0]   rd_word = '0;
    int            wr_mode = 0;
    logic          wr_rand = 1'b1;
    logic          poke_en = 1'b0;
    logic [AW-1:0] poke_addr = '0;
    logic [31:0]   poke_data = '0;

    assign i_mem_rd_valid = (rd_count == 1);
    assign i_mem_data     = rd_word;
    assign i_mem_wr_ready = (wr_mode == 0) ? 1'b1 : ((wr_mode == 1) ? wr_rand : 1'b0);

    // Memory array and read pipeline.
    always @(posedge i_clk) begin
        wr_rand <= 1'($urandom_range(0, 1));
        if (o_mem_rd_ready) begin
            rd_count <= rd_lat;
            rd_word  <= bram[o_mem_addr];
        end else if (rd_count != 0) begin
            rd_count <= rd_count - 1;
        end
        if (poke_en) begin
            bram[poke_addr] <= poke_data;
        end else if (o_mem_wr_valid && i_mem_wr_ready) begin
            bram[o_mem_addr] <= o_mem_data;
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Reference behaviour from the byte-addressed view of memory.
    function automatic exp_t model(input logic wr, input logic [1:0] sz, input logic uns,
                                   input logic [31:0] a, input logic [31:0] wd, input logic commit);
        exp_t e;
        int n;
        int base;
        int wbase;
        logic [31:0] v;
        logic [7:0] b [4];
        base  = int'(a[11:0]);
        wbase = base & ~3;
        e.maddr = a[11:2];
        e.rdata = 32'h0;
        e.wdata = 32'h0;
        e.reads = 0;
        e.writes = 0;
        e.lat = 1;
        e.acc = 0;
        e.chk_lat = 1'b0;
        e.err = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
        if (e.err) return e;
        n = 1 << sz;
        if (!wr) begin
            v = 32'h0;
            for (int i = 0; i < n; i++) v = v | (32'(ref_mem[base + i]) << (8 * i));
            if (!uns && n < 4 && v[8 * n - 1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
            e.rdata = v;
            e.reads = 1;
            e.lat = 3;
        end else begin
            for (int i = 0; i < 4; i++) b[i] = ref_mem[wbase + i];
            for (int i = 0; i < n; i++) b[(base & 3) + i] = wd[8 * i +: 8];
            e.wdata = {b[3], b[2], b[1], b[0]};
            if (commit) for (int i = 0; i < 4; i++) ref_mem[wbase + i] = b[i];
            e.reads = (n < 4) ? 1 : 0;
            e.writes = 1;
            e.lat = (n < 4) ? 4 : 2;
        end
        return e;
    endfunction

    int txn_reads = 0;
    int txn_writes = 0;
    int total_writes = 0;

    // Monitor: checks memory-side traffic and pops the scoreboard on each response.
    initial begin
        exp_t e;
        forever begin
            @(negedge i_clk);
            if (i_rst) begin
                sb.delete();
                txn_reads = 0;
                txn_writes = 0;
            end else begin
                if (o_mem_rd_ready || o_mem_wr_valid) begin
                    check_output("strobe_exclusive", 32'(o_mem_rd_ready & o_mem_wr_valid), 32'd0);
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_mem_access: got rd=%0b wr=%0b, want none", o_mem_rd_ready, o_mem_wr_valid);
                    end else begin
                        check_output("mem_addr", 32'(o_mem_addr), 32'(sb[0].maddr));
                    end
                end
                if (o_mem_rd_ready) txn_reads++;
                if (o_mem_wr_valid && i_mem_wr_ready) begin
                    txn_writes++;
                    total_writes++;
                    if (sb.size() != 0) check_output("mem_wdata", o_mem_data, sb[0].wdata);
                end
                if (o_resp_valid) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_resp: got resp rdata=0x%08h, want no response", o_resp_rdata);
                    end else begin
                        e = sb.pop_front();
                        check_output("resp_rdata", o_resp_rdata, e.rdata);
                        check_output("resp_err", 32'(o_resp_err), 32'(e.err));
                        check_output("resp_reads", 32'(txn_reads), 32'(e.reads));
                        check_output("resp_writes", 32'(txn_writes), 32'(e.writes));
                        check_output("resp_mem_data_idle", o_mem_data, 32'h0);
                        if (e.chk_lat) check_output("resp_latency", 32'(cyc - e.acc), 32'(e.lat));
                    end
                    txn_reads = 0;
                    txn_writes = 0;
                end
            end
        end
    end

    task automatic poke(input logic [AW-1:0] wa, input logic [31:0] d);
        poke_en = 1'b1;
        poke_addr = wa;
        poke_data = d;
        @(posedge i_clk);
        #1;
        poke_en = 1'b0;
        for (int i = 0; i < 4; i++) ref_mem[{wa, 2'(i)}] = d[8 * i +: 8];
    endtask

    // Drive one request, wait (bounded) for accept, and log the expected response.
    task automatic apply_stimulus(input logic wr, input logic [1:0] sz, input logic uns,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  input logic hold, input logic chk_lat, input logic abandon,
                                  output int acc);
        exp_t e;
        int budget;
        @(posedge i_clk);
        #1;
        i_req_valid = 1'b1;
        i_req_write = wr;
        i_req_size = sz;
        i_req_unsigned = uns;
        i_req_addr = a;
        i_req_wdata = wd;
        budget = 0;
        @(negedge i_clk);
        while (!o_req_ready && budget < 200) begin
            @(negedge i_clk);
            budget++;
        end
        if (!o_req_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: got ready=0, want ready=1 within 200 cycles");
            i_req_valid = 1'b0;
            acc = -1;
            return;
        end
        acc = cyc;
        e = model(wr, sz, uns, a, wd, !abandon);
        e.acc = cyc;
        e.chk_lat = chk_lat;
        sb.push_back(e);
        @(posedge i_clk);
        #1;
        if (!hold) i_req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb.size() != 0 || !o_req_ready) && n < 300) begin
            @(negedge i_clk);
            n++;
        end
        if (n >= 300) begin
            checks++;
            errors++;
            $display("[TB] FAIL idle_timeout: got %0d pending, want 0", sb.size());
        end
    endtask

    function automatic logic any_output();
        return o_req_ready | o_resp_valid | (|o_resp_rdata) | o_resp_err | (|o_mem_addr) |
               (|o_mem_data) | o_mem_wr_valid | o_mem_rd_ready;
    endfunction

    initial begin
        int acc0, acc1, acc2;
        int wr_before;
        logic [31:0] word_before;
        logic [31:0] a;
        logic [1:0] sz;
        int r;

        i_rst = 1'b1;
        i_req_valid = 1'b0;
        i_req_write = 1'b0;
        i_req_size = 2'b00;
        i_req_unsigned = 1'b0;
        i_req_addr = 32'h0;
        i_req_wdata = 32'h0;

        for (int w = 0; w < 16; w++) poke(AW'(10'h40 + w), $urandom());
        @(negedge i_clk);
        check_output("reset_outputs_zero", 32'(any_output()), 32'd0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        check_output("ready_after_reset", 32'(o_req_ready), 32'd1);

        $display("[TB] directed loads");
        poke(10'h40, 32'h80FF7F01);
        apply_stimulus(1'b0, 2'd0, 1'b0, 32'h0000_0102, 32'h0, 1'b0, 1'b1, 1'b0, acc0); wait_idle();
        apply_stimulus(1'b0, 2'd0, 1'b1, 32'h0000_0102, 32'h0, 1'b0, 1'b1, 1'b0, acc0); wait_idle();
        apply_stimulus(1'b0, 2'd1, 1'b0, 32'h0000_0102, 32'h0, 1'b0, 1'b1, 1'b0, acc0); wait_idle();
        apply_stimulus(1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0, 1'b0, 1'b1, 1'b0, acc0); wait_idle();

        $display("[TB] directed stores and errors");
        poke(10'h40, 32'h41424344);
        apply_stimulus(1'b1, 2'd0, 1'b0, 32'h0000_0103, 32'h0000_00AA, 1'b0, 1'b1, 1'b0, acc0); wait_idle();
        check_output("sb_merged_word", bram[10'h40], 32'hAA424344);
        apply_stimulus(1'b1, 2'd2, 1'b0, 32'h0000_0100, 32'h11223344, 1'b0, 1'b1, 1'b0, acc0); wait_idle();
        apply_stimulus(1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0, 1'b0, 1'b1, 1'b0, acc0); wait_idle();
        apply_stimulus(1'b1, 2'd1, 1'b0, 32'h0000_0101, 32'h0000_BEEF, 1'b0, 1'b1, 1'b0, acc0); wait_idle();
        apply_stimulus(1'b0, 2'd3, 1'b0, 32'h0000_0100, 32'h0, 1'b0, 1'b1, 1'b0, acc0); wait_idle();
        apply_stimulus(1'b1, 2'd1, 1'b0, 32'hFFFF_F106, 32'hFFFF_8001, 1'b0, 1'b1, 1'b0, acc0); wait_idle();

        $display("[TB] back-to-back loads");
        poke(10'h43, 32'hCAFEF00D);
        apply_stimulus(1'b0, 2'd2, 1'b0, 32'h0000_010C, 32'h0, 1'b1, 1'b1, 1'b0, acc0);
        apply_stimulus(1'b0, 2'd1, 1'b1, 32'h0000_010E, 32'h0, 1'b1, 1'b1, 1'b0, acc1);
        apply_stimulus(1'b0, 2'd0, 1'b0, 32'h0000_010D, 32'h0, 1'b0, 1'b1, 1'b0, acc2);
        wait_idle();
        check_output("b2b_accept_1", 32'(acc1), 32'(acc0 + 4));
        check_output("b2b_accept_2", 32'(acc2), 32'(acc1 + 4));

        $display("[TB] reset during read wait");
        rd_lat = 6;
        wr_before = total_writes;
        word_before = bram[10'h41];
        apply_stimulus(1'b1, 2'd0, 1'b0, 32'h0000_0105, 32'h0000_005A, 1'b0, 1'b0, 1'b1, acc0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        @(negedge i_clk);
        check_output("rdwait_reset_outputs_zero", 32'(any_output()), 32'd0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        check_output("rdwait_ready_after_reset", 32'(o_req_ready), 32'd1);
        repeat (10) @(negedge i_clk);
        check_output("rdwait_no_write", 32'(total_writes), 32'(wr_before));
        check_output("rdwait_mem_unchanged", bram[10'h41], word_before);
        check_output("rdwait_still_idle", 32'(o_req_ready), 32'd1);
        rd_lat = 1;
        apply_stimulus(1'b0, 2'd2, 1'b0, 32'h0000_0104, 32'h0, 1'b0, 1'b1, 1'b0, acc0); wait_idle();

        $display("[TB] reset during stalled write");
        wr_mode = 2;
        wr_before = total_writes;
        word_before = bram[10'h42];
        apply_stimulus(1'b1, 2'd2, 1'b0, 32'h0000_0108, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, acc0);
        i_rst = 1'b1;
        @(negedge i_clk);
        check_output("wr_reset_no_wr_valid", 32'(o_mem_wr_valid), 32'd0);
        check_output("wr_reset_outputs_zero", 32'(any_output()), 32'd0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        wr_mode = 0;
        repeat (4) @(negedge i_clk);
        check_output("wr_reset_no_write", 32'(total_writes), 32'(wr_before));
        check_output("wr_reset_mem_unchanged", bram[10'h42], word_before);

        $display("[TB] randomized traffic");
        wr_mode = 1;
        for (int t = 0; t < 150; t++) begin
            rd_lat = $urandom_range(1, 3);
            r = $urandom_range(0, 9);
            sz = (r < 3) ? 2'd0 : ((r < 6) ? 2'd1 : ((r < 9) ? 2'd2 : 2'd3));
            a = $urandom();
            a[11:2] = 10'h40 + 10'($urandom_range(0, 15));
            apply_stimulus(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom(),
                           1'b0, 1'b0, 1'b0, acc0);
            wait_idle();
        end
        wr_mode = 0;
        rd_lat = 1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time bound so the bench always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no completion, want finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
